// File: rtl/seq_mul_ctrl.sv
// Sequencing controller for an 8x8 shift-add multiplier datapath: operand/result handshakes, clear and add-enable drive.
// Optional zero-operand shortcut enabled by defining SEQ_MUL_ZERO_BYPASS_EN.
module seq_mul_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [WIDTH-1:0]   dp_mul,
    output logic               dp_test,
    output logic               dp_clr,
    input  logic [2*WIDTH-1:0] dp_prod,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_data,
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_sh;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_iter;

    assign accept    = op_valid && (state == IDLE);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef SEQ_MUL_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (op_a == '0) || (op_b == '0);
`endif

    // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef SEQ_MUL_ZERO_BYPASS_EN
                    state_nxt = zero_op ? DONE : CLEAR;
`else
                    state_nxt = CLEAR;
`endif
                end
            end
            CLEAR:   state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = CAPT;
            CAPT:    state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg    <= '0;
            b_sh     <= '0;
            cnt      <= '0;
            res_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= op_a;
                        b_sh  <= op_b;
                        cnt   <= '0;
`ifdef SEQ_MUL_ZERO_BYPASS_EN
                        if (zero_op) res_data <= '0;
`endif
                    end
                end
                RUN: begin
                    b_sh <= b_sh >> 1;
                    cnt  <= last_iter ? '0 : cnt + CNT_W'(1);
                end
                // dp_prod is only trusted here: the datapath keeps shifting in every other state.
                CAPT:    res_data <= dp_prod;
                default: ;
            endcase
        end
    end

    // Handshake and datapath controls decode straight from state, so reset drops them immediately.
    assign op_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dp_clr    = (state == CLEAR);
    assign dp_test   = (state == RUN) && b_sh[0];
    assign res_valid = (state == DONE);
    assign dp_mul    = a_reg;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Self-checking bench for seq_mul_ctrl: shift-add datapath model, transaction-level reference model, directed scenarios.
// Expectations follow SEQ_MUL_ZERO_BYPASS_EN when the bench is compiled with it defined.
module tb_seq_mul_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           op_valid;
    logic           op_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   dp_mul;
    logic           dp_test;
    logic           dp_clr;
    logic [2*W-1:0] dp_prod;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_data;
    logic           busy;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    seq_mul_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .dp_mul(dp_mul), .dp_test(dp_test), .dp_clr(dp_clr), .dp_prod(dp_prod),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Shift-add datapath: add multiplicand into the upper half when enabled, shift right every clock.
    logic [2*W:0] dp_sum;
    assign dp_sum = {1'b0, dp_prod} + (dp_test ? {1'b0, dp_mul, {W{1'b0}}} : '0);

    always @(posedge clk or negedge reset) begin
        if (!reset)      dp_prod <= '0;
        else if (dp_clr) dp_prod <= '0;
        else             dp_prod <= dp_sum[2*W:1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: m_k is the cycle number counted from the acceptance edge (cycle 1 follows it).
    bit         m_active = 1'b0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    int         m_k = 0;

    function automatic int done_cycle(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MUL_ZERO_BYPASS_EN
        if (a == '0 || b == '0) return 1;
`endif
        return W + 3;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_a      <= '0;
            m_b      <= '0;
            m_k      <= 0;
        end else if (!m_active) begin
            if (op_valid) begin
                m_active <= 1'b1;
                m_a      <= op_a;
                m_b      <= op_b;
                m_k      <= 1;
            end
        end else if (m_k >= done_cycle(m_a, m_b) && res_ready) begin
            m_active <= 1'b0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            int dk;
            logic [2*W-1:0] prod;
            logic exp_test;
            dk   = done_cycle(m_a, m_b);
            prod = m_a * m_b;
            exp_test = m_active && m_k >= 2 && m_k <= W + 1 && dk != 1 && m_b[m_k - 2];
            check("op_ready",  op_ready,  !m_active);
            check("busy",      busy,      m_active);
            check("dp_mul",    dp_mul,    m_a);
            check("dp_clr",    dp_clr,    m_active && m_k == 1 && dk != 1);
            check("dp_test",   dp_test,   exp_test);
            check("res_valid", res_valid, m_active && m_k >= dk);
            if (m_active && m_k >= dk) check("res_data", res_data, prod);
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic rr);
        @(negedge clk);
        op_a = a; op_b = b; op_valid = 1'b1; res_ready = rr;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // Starts in cycle 1; returns the cycle at which res_valid was first seen plus clr/test pulse counts.
    task automatic wait_res(input bit inject, output int lat, output int nt, output int nc);
        lat = 1; nt = 0; nc = 0;
        while (lat < 64) begin
            if (dp_clr)  nc++;
            if (dp_test) nt++;
            if (res_valid) break;
            if (inject && lat == 4) begin op_valid = 1'b1; op_a = 8'h77; op_b = 8'h99; end
            if (inject && lat == 7) op_valid = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("res_valid_seen", res_valid, 1'b1);
    endtask

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input logic [2*W-1:0] exp_data, input int exp_lat,
                         input bit inject, output int nt, output int nc);
        int lat;
        start_op(a, b, hold == 0);
        wait_res(inject, lat, nt, nc);
        check({name, "_lat"},  lat,      exp_lat);
        check({name, "_data"}, res_data, exp_data);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            check({name, "_hold_valid"}, res_valid, 1'b1);
            check({name, "_hold_data"},  res_data,  exp_data);
            check({name, "_hold_ready"}, op_ready,  1'b0);
            if (i == 2) begin op_valid = 1'b1; op_a = 8'h44; op_b = 8'h55; end
        end
        if (hold > 0) begin
            op_valid  = 1'b0;
            res_ready = 1'b1;
        end
        @(negedge clk); #1;
        check({name, "_idle_ready"}, op_ready,  1'b1);
        check({name, "_idle_valid"}, res_valid, 1'b0);
        res_ready = 1'b0;
    endtask

    initial begin
        int nt, nc, lat;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0; reset = 1'b1;
        #3 reset = 1'b0;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_op_ready",  op_ready,  1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_dp_clr",    dp_clr,    1'b0);
        check("rst_dp_test",   dp_test,   1'b0);
        check("rst_res_data",  res_data,  16'h0000);
        check("rst_dp_mul",    dp_mul,    8'h00);
        @(negedge clk); #2 reset = 1'b1;

        do_op("m13x11", 8'd13, 8'd11, 0, 16'h008F, 11, 1'b0, nt, nc);
        check("m13x11_test_cnt", nt, 3);
        check("m13x11_clr_cnt",  nc, 1);

        do_op("mffxff", 8'hFF, 8'hFF, 0, 16'hFE01, 11, 1'b0, nt, nc);
        check("mffxff_test_cnt", nt, 8);
        check("mffxff_clr_cnt",  nc, 1);

`ifdef SEQ_MUL_ZERO_BYPASS_EN
        do_op("zero_b", 8'h5A, 8'h00, 0, 16'h0000, 1, 1'b0, nt, nc);
        check("zero_b_clr_cnt", nc, 0);
`else
        do_op("zero_b", 8'h5A, 8'h00, 0, 16'h0000, 11, 1'b0, nt, nc);
        check("zero_b_clr_cnt", nc, 1);
`endif
        check("zero_b_test_cnt", nt, 0);

        do_op("hold", 8'h0C, 8'h0D, 6, 16'h009C, 11, 1'b0, nt, nc);
        do_op("inject", 8'h5C, 8'hA3, 0, 16'h3A94, 11, 1'b1, nt, nc);

        // Reset during RUN cycle 4 (cycle 5 after acceptance).
        start_op(8'h21, 8'h35, 1'b1);
        repeat (4) @(negedge clk);
        check("mid_run_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("mid_run_rst_valid", res_valid, 1'b0);
        check("mid_run_rst_ready", op_ready,  1'b1);
        check("mid_run_rst_test",  dp_test,   1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        do_op("m7x9", 8'd7, 8'd9, 0, 16'h003F, 11, 1'b0, nt, nc);

        // Reset while a result waits in DONE: res_valid must drop without a clock edge.
        start_op(8'h12, 8'h34, 1'b0);
        wait_res(1'b0, lat, nt, nc);
        #2 reset = 1'b0;
        #1;
        check("done_rst_valid", res_valid, 1'b0);
        check("done_rst_data",  res_data,  16'h0000);
        @(negedge clk); #2 reset = 1'b1;
        do_op("after_done_rst", 8'd3, 8'd5, 0, 16'h000F, 11, 1'b0, nt, nc);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
